// File: rtl/conv_output_collector_if.sv
// Result-stream bus between a convolution kernel source and the output collector.
interface conv_output_collector_if #(
  parameter int unsigned DATA_WIDHT = 32,
  parameter int unsigned ADDR_WIDHT = 16
);
  logic                  Start;
  logic [ADDR_WIDHT-1:0] Base_Addr;
  logic [DATA_WIDHT-1:0] Data_In;
  logic                  Valid_in;
  logic                  Wr_En;
  logic [ADDR_WIDHT-1:0] Wr_Addr;
  logic [DATA_WIDHT-1:0] Wr_Data;
  logic [15:0]           Row;
  logic [15:0]           Col;
  logic                  Busy;
  logic                  Frame_Done;
  logic                  Drop_Err;
  logic [DATA_WIDHT-1:0] Checksum;

  // Stimulus side: drives control and result words, observes the write port.
  modport master (
    output Start, Base_Addr, Data_In, Valid_in,
    input  Wr_En, Wr_Addr, Wr_Data, Row, Col, Busy, Frame_Done, Drop_Err, Checksum
  );

  // Collector side.
  modport slave (
    input  Start, Base_Addr, Data_In, Valid_in,
    output Wr_En, Wr_Addr, Wr_Data, Row, Col, Busy, Frame_Done, Drop_Err, Checksum
  );
endinterface

// File: rtl/conv_output_collector.sv
// Collects one frame of kernel results, writes them raster-ordered from a base
// address, tracks output row/col and produces an XOR checksum per frame.
module conv_output_collector #(
  parameter int unsigned DATA_WIDHT  = 32,
  parameter int unsigned IMG_WIDHT   = 220,
  parameter int unsigned IMG_HEIGHT  = 220,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned STRIDE      = 1,
  parameter int unsigned ADDR_WIDHT  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  conv_output_collector_if.slave  io_bus
);

  localparam int unsigned OUT_W = (IMG_WIDHT  - KERNEL_SIZE) / STRIDE + 1;
  localparam int unsigned OUT_H = (IMG_HEIGHT - KERNEL_SIZE) / STRIDE + 1;
  localparam logic [15:0] COL_LAST = 16'(OUT_W - 1);
  localparam logic [15:0] ROW_LAST = 16'(OUT_H - 1);

  typedef enum logic {S_IDLE = 1'b0, S_COLLECT = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_busy;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_start;
  logic                  w_last;

  logic [ADDR_WIDHT-1:0] r_base;
  logic [ADDR_WIDHT-1:0] r_idx;
  logic [15:0]           r_row_cnt;
  logic [15:0]           r_col_cnt;

  logic                  r_wr_en;
  logic [ADDR_WIDHT-1:0] r_wr_addr;
  logic [DATA_WIDHT-1:0] r_wr_data;
  logic [15:0]           r_row;
  logic [15:0]           r_col;
  logic                  r_frame_done;
  logic                  r_drop_err;
  logic [DATA_WIDHT-1:0] r_checksum;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: Start arms a frame, the final raster position ends it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (io_bus.Start) w_state_nxt = S_COLLECT;
      S_COLLECT: if (w_last)       w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Beat classification for the current state.
  always_comb begin
    w_busy   = (r_state == S_COLLECT);
    w_accept = w_busy  & io_bus.Valid_in;
    w_drop   = !w_busy & io_bus.Valid_in;
    w_start  = !w_busy & io_bus.Start;
    w_last   = w_accept && (r_row_cnt == ROW_LAST) && (r_col_cnt == COL_LAST);
  end

  // Frame setup, position counters and registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base       <= '0;
      r_idx        <= '0;
      r_row_cnt    <= '0;
      r_col_cnt    <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_frame_done <= 1'b0;
      r_drop_err   <= 1'b0;
      r_checksum   <= '0;
    end else begin
      r_wr_en      <= w_accept;
      r_frame_done <= w_last;
      if (w_start) begin
        r_base     <= io_bus.Base_Addr;
        r_idx      <= '0;
        r_row_cnt  <= '0;
        r_col_cnt  <= '0;
        r_checksum <= '0;
      end
      // A stray beat outranks the clear done by Start in the same cycle.
      if (w_drop)       r_drop_err <= 1'b1;
      else if (w_start) r_drop_err <= 1'b0;
      if (w_accept) begin
        r_wr_addr  <= r_base + r_idx;
        r_wr_data  <= io_bus.Data_In;
        r_row      <= r_row_cnt;
        r_col      <= r_col_cnt;
        r_checksum <= r_checksum ^ io_bus.Data_In;
        if (w_last) begin
          r_idx     <= '0;
          r_row_cnt <= '0;
          r_col_cnt <= '0;
        end else begin
          r_idx <= r_idx + ADDR_WIDHT'(1);
          if (r_col_cnt == COL_LAST) begin
            r_col_cnt <= '0;
            r_row_cnt <= r_row_cnt + 16'd1;
          end else begin
            r_col_cnt <= r_col_cnt + 16'd1;
          end
        end
      end
    end
  end

  assign io_bus.Wr_En      = r_wr_en;
  assign io_bus.Wr_Addr    = r_wr_addr;
  assign io_bus.Wr_Data    = r_wr_data;
  assign io_bus.Row        = r_row;
  assign io_bus.Col        = r_col;
  assign io_bus.Busy       = w_busy;
  assign io_bus.Frame_Done = r_frame_done;
  assign io_bus.Drop_Err   = r_drop_err;
  assign io_bus.Checksum   = r_checksum;

endmodule
